// File: rtl/alu_pkg.sv
// alu_pkg: ALU select codes shared with ALU_ControlUnit, plus the skid-buffer occupancy states
package alu_pkg;
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_INVALID = 4'b1111;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;
endpackage

// File: rtl/alu_skid_buffer.sv
// alu_skid_buffer: 2-entry valid/ready skid buffer, in_ready decoded only from registered state
module alu_skid_buffer #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  import alu_pkg::*;
  skid_state_t state, state_nxt;
  logic [W-1:0] main_q, skid_q;
  logic accept, deliver;
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;
  always_comb begin
    state_nxt = state;
    state_nxt = state == EMPTY ? (accept ? ONE : EMPTY)
              : state == ONE   ? (accept && !deliver ? FULL : !accept && deliver ? EMPTY : ONE)
              : (deliver ? ONE : FULL);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (state == FULL && deliver) main_q <= skid_q;
      else if (accept && (!out_valid || deliver)) main_q <= in_data;
      if (accept && out_valid && !deliver) skid_q <= in_data;
    end
  end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU execute stage with valid/ready handshakes and an output skid buffer
module alu_exec_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_sel,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic             illegal,
  output logic             err_sticky,
  output logic [CNT_W-1:0] op_count
);
  import alu_pkg::*;
  logic [XLEN-1:0] res;
  logic            ill;
  logic [XLEN+1:0] entry;
  always_comb begin
    ill = alu_sel == ALU_INVALID || !(alu_sel inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB});
    res = alu_sel == ALU_AND ? op_a & op_b
        : alu_sel == ALU_OR  ? op_a | op_b
        : alu_sel == ALU_ADD ? op_a + op_b
        : alu_sel == ALU_SUB ? op_a - op_b
        : '0;
  end
  alu_skid_buffer #(.W(XLEN + 2)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   ({res, res == '0, ill}),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (entry)
  );
  assign {result, zero, illegal} = entry;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      op_count   <= '0;
    end else begin
      err_sticky <= err_sticky | (in_valid & in_ready & ill);
      op_count   <= op_count + CNT_W'(out_valid & out_ready);
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vectors; expected entries queued on accept, monitor checks on delivery
module tb_alu_exec_stage;
  logic        clk = 0, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  alu_sel;
  logic [31:0] op_a, op_b, result;
  logic        zero, illegal, err_sticky;
  logic [15:0] op_count;
  logic [33:0] q[$];
  int n_cmp = 0, n_bad = 0;

  alu_exec_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .alu_sel(alu_sel),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal), .err_sticky(err_sticky), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic z, input logic il);
    alu_sel = s; op_a = a; op_b = b; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back({r, z, il});
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_cmp++; n_bad++;
    $display("FAIL send_timeout: in_ready stuck low for sel %b", s);
    in_valid = 1'b0;
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_delivery: got result %0h with empty scoreboard", result);
      end else begin
        logic [33:0] e;
        e = q.pop_front();
        if ({result, zero, illegal} !== e) begin
          n_bad++;
          $display("FAIL delivery: got res=%0h z=%b il=%b expected res=%0h z=%b il=%b",
                   result, zero, illegal, e[33:2], e[1], e[0]);
        end
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; in_valid = 1; out_ready = 1; alu_sel = 4'b0010; op_a = 7; op_b = 5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_op_count", 64'(op_count), 64'd0);
    end
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_err", 64'(err_sticky), 64'd0);
    in_valid = 0;
    rst_n = 1;
    @(posedge clk); #1;

    send(4'b0010, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0);
    chk("add_latency_valid", 64'(out_valid), 64'd1);
    chk("add_latency_result", 64'(result), 64'd12);
    send(4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send(4'b0110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
    chk("sub_zero", 64'(zero), 64'd1);
    send(4'b0000, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0);
    chk("and_latency_result", 64'(result), 64'hF000);
    send(4'b0001, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 1'b0);
    chk("or_latency_result", 64'(result), 64'hFFF0);
    repeat (3) @(posedge clk); #1;
    chk("count_after_basic", 64'(op_count), 64'd5);
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    out_ready = 0;
    send(4'b0010, 32'd100, 32'd1, 32'd101, 1'b0, 1'b0);
    chk("bp_in_ready_one", 64'(in_ready), 64'd1);
    send(4'b0110, 32'd100, 32'd1, 32'd99, 1'b0, 1'b0);
    chk("bp_in_ready_full", 64'(in_ready), 64'd0);
    fork
      send(4'b0001, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1'b0);
      begin
        repeat (3) @(posedge clk); #1;
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_result", 64'(result), 64'd101);
        chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("bp_op_count", 64'(op_count), 64'd8);
    chk("bp_drained", 64'(q.size()), 64'd0);

    send(4'b1111, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1);
    chk("illegal_flag", 64'(illegal), 64'd1);
    chk("illegal_err_set", 64'(err_sticky), 64'd1);
    send(4'b0101, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1);
    send(4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("err_persists", 64'(err_sticky), 64'd1);
    chk("illegal_clears", 64'(illegal), 64'd0);
    chk("ill_op_count", 64'(op_count), 64'd11);

    out_ready = 0;
    send(4'b0010, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0);
    send(4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 0;
    q.delete();
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    chk("async_op_count", 64'(op_count), 64'd0);
    chk("async_err", 64'(err_sticky), 64'd0);
    chk("async_result", 64'(result), 64'd0);
    out_ready = 1;
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(posedge clk); #1;
    chk("no_stale_valid", 64'(out_valid), 64'd0);
    chk("no_stale_count", 64'(op_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
